// File: rtl/cpu_pkg.sv
// Shared core types: machine word, fetch-queue entry, and fetch defaults.
package cpu_pkg;

  localparam int unsigned CPU_XLEN = 32;
  localparam logic [CPU_XLEN-1:0] CPU_RESET_PC = 32'h0000_0000;

  typedef logic [CPU_XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry prefetch FIFO of {pc, instruction}; flush beats push and pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;
  fetch_entry_t     mem_q [DEPTH];
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot in the same edge, so a full queue may still take a push
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[tail_ptr] <= entry;
  end

  assign head  = empty ? '0 : mem_q[head_ptr];
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: issues sequential fetches into a prefetch queue, handles redirects.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = CPU_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instruction_ready,
  output logic [XLEN-1:0] instruction_addr,
  input  logic            instruction_wait,
  input  logic [XLEN-1:0] instruction,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instruction,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_accept,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned     CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  addr_q;
  logic             pending_q;
  logic             drop_q;
  logic             run_q;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     entry;
  logic             complete;
  logic             stall;
  logic             push;
  logic             pop;

  assign instruction_ready = run_q && (pending_q || (count < CNT_W'(DEPTH)));
  assign complete          = instruction_ready && !instruction_wait;
  assign stall             = instruction_ready && instruction_wait;
  assign push              = complete && !drop_q && !redirect;
  assign pop               = dec_valid && dec_accept;

  // a stalled request keeps its own address so a redirect can move pc_q underneath it
  assign instruction_addr = pending_q ? addr_q : pc_q;

  assign dec_valid       = (count != '0);
  assign dec_pc          = head.pc;
  assign dec_instruction = head.instruction;
  assign entry           = '{pc: pc_q, instruction: instruction};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      pending_q <= stall;
      if (stall && !pending_q) addr_q <= pc_q;
      drop_q <= (drop_q && !complete) || (redirect && stall);
      if (redirect)  pc_q <= redirect_pc & ALIGN_MASK;
      else if (push) pc_q <= pc_q + XLEN'(4);
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect),
    .push (push),
    .entry(entry),
    .pop  (pop),
    .head (head),
    .count(count)
  );

endmodule
